pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard and forwarding controller for the decode stage of the in-order DMEM/ALU pipeline.
- Tracks destination registers of instructions in flight across NUM_STAGES post-decode stages in a shadow shift register.
- Selects forwarded operand data from any tracked stage and stalls IF/ID on load-use hazards.
- Supersedes the single-stage, compare-only forwarding check, which had no stall or flush handling.

---
 rtl/pipe_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard and forwarding controller.
// A shadow shift register records {valid, wr_en, is_load, rd} for every
// instruction in flight after ID. Operands are forwarded from the youngest
// in-flight producer. IF/ID is stalled while a load feeding a source operand
// has not yet reached the entry where its data becomes valid.
// Optional macro HAZARD_PERF_EN adds saturating stall/forward event counters.
module pipe_hazard_ctrl #(
    parameter int DATA_WIDTH         = 64,
    parameter int REG_ADDRESS_LENGTH = 5,
    parameter int NUM_STAGES         = 3,
    parameter int LOAD_LATENCY       = 1,
    parameter int ZERO_REG_HARDWIRED = 0,
    localparam int SEL_W             = $clog2(NUM_STAGES + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               id_valid,
    input  logic [REG_ADDRESS_LENGTH-1:0]      id_ra_addr,
    input  logic [REG_ADDRESS_LENGTH-1:0]      id_rb_addr,
    input  logic                               id_ra_used,
    input  logic                               id_rb_used,
    input  logic [REG_ADDRESS_LENGTH-1:0]      id_rd_addr,
    input  logic                               id_wr_en,
    input  logic                               id_is_load,
    input  logic [DATA_WIDTH-1:0]              id_ra_data,
    input  logic [DATA_WIDTH-1:0]              id_rb_data,
    input  logic [NUM_STAGES*DATA_WIDTH-1:0]   stage_result,
    input  logic                               flush,
    output logic                               stall,
    output logic                               issue,
    output logic [DATA_WIDTH-1:0]              fwd_ra_data,
    output logic [DATA_WIDTH-1:0]              fwd_rb_data,
    output logic [SEL_W-1:0]                   fwd_ra_sel,
    output logic [SEL_W-1:0]                   fwd_rb_sel
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]                        stall_cycles,
    output logic [31:0]                        fwd_events
`endif
);

    // Shadow pipeline: entry 0 is the stage right after ID.
    logic [NUM_STAGES-1:0]                         ent_vld_q, ent_vld_d;
    logic [NUM_STAGES-1:0]                         ent_wr_q,  ent_wr_d;
    logic [NUM_STAGES-1:0]                         ent_ld_q,  ent_ld_d;
    logic [NUM_STAGES-1:0][REG_ADDRESS_LENGTH-1:0] ent_rd_q,  ent_rd_d;

    logic [NUM_STAGES-1:0] match_a, match_b;
    logic                  haz_a, haz_b;
    logic                  zero_a, zero_b;

    // Per-entry source match; address 0 is masked when it is hardwired.
    always_comb begin
        zero_a = (ZERO_REG_HARDWIRED != 0) && (id_ra_addr == '0);
        zero_b = (ZERO_REG_HARDWIRED != 0) && (id_rb_addr == '0);
        for (int k = 0; k < NUM_STAGES; k++) begin
            match_a[k] = ent_vld_q[k] & ent_wr_q[k] & (ent_rd_q[k] == id_ra_addr)
                         & id_ra_used & ~zero_a;
            match_b[k] = ent_vld_q[k] & ent_wr_q[k] & (ent_rd_q[k] == id_rb_addr)
                         & id_rb_used & ~zero_b;
        end
    end

    // Youngest-producer select: scan oldest to youngest so the lowest k wins.
    // The winning entry alone decides whether the operand is a load-use hazard.
    always_comb begin
        fwd_ra_sel  = '0;
        fwd_rb_sel  = '0;
        fwd_ra_data = id_ra_data;
        fwd_rb_data = id_rb_data;
        haz_a       = 1'b0;
        haz_b       = 1'b0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (match_a[k]) begin
                fwd_ra_sel  = SEL_W'(k + 1);
                fwd_ra_data = stage_result[k*DATA_WIDTH +: DATA_WIDTH];
                haz_a       = ent_ld_q[k] && (k < LOAD_LATENCY);
            end
            if (match_b[k]) begin
                fwd_rb_sel  = SEL_W'(k + 1);
                fwd_rb_data = stage_result[k*DATA_WIDTH +: DATA_WIDTH];
                haz_b       = ent_ld_q[k] && (k < LOAD_LATENCY);
            end
        end
    end

    // Flush overrides a hazard: the ID instruction is dead, so nothing to wait for.
    always_comb begin
        stall = id_valid & (haz_a | haz_b) & ~flush;
        issue = id_valid & ~stall & ~flush;
    end

    // Next shadow state: shift toward write-back, bubble when ID does not issue.
    always_comb begin
        for (int k = NUM_STAGES - 1; k >= 1; k--) begin
            ent_vld_d[k] = ent_vld_q[k-1];
            ent_wr_d[k]  = ent_wr_q[k-1];
            ent_ld_d[k]  = ent_ld_q[k-1];
            ent_rd_d[k]  = ent_rd_q[k-1];
        end
        ent_vld_d[0] = issue;
        ent_wr_d[0]  = id_wr_en;
        ent_ld_d[0]  = id_is_load;
        ent_rd_d[0]  = id_rd_addr;
    end

    // Shadow register update with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_vld_q <= '0;
            ent_wr_q  <= '0;
            ent_ld_q  <= '0;
            ent_rd_q  <= '0;
        end else begin
            ent_vld_q <= ent_vld_d;
            ent_wr_q  <= ent_wr_d;
            ent_ld_q  <= ent_ld_d;
            ent_rd_q  <= ent_rd_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] fwd_events_q,   fwd_events_d;

    // Saturating event counters.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        fwd_events_d   = fwd_events_q;
        if (stall && !(&stall_cycles_q))
            stall_cycles_d = stall_cycles_q + 32'd1;
        if (issue && ((fwd_ra_sel != '0) || (fwd_rb_sel != '0)) && !(&fwd_events_q))
            fwd_events_d = fwd_events_q + 32'd1;
    end

    // Counter registers, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            fwd_events_q   <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            fwd_events_q   <= fwd_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign fwd_events   = fwd_events_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed steps then random traffic, checked
// against a queue-based model of in-flight instructions. Two instances are
// driven with identical inputs: one with r0 ordinary, one with r0 hardwired.
module tb_pipe_hazard_ctrl;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NS = 3;
    localparam int LL = 1;

    typedef struct packed {
        bit          v;
        bit          wr;
        bit          ld;
        logic [AW-1:0] rd;
    } ent_t;
    typedef ent_t eq_t[$];

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_ra_used, id_rb_used, id_wr_en, id_is_load, flush;
    logic [AW-1:0] id_ra_addr, id_rb_addr, id_rd_addr;
    logic [DW-1:0] id_ra_data, id_rb_data;
    logic [DW-1:0] sr [NS];
    logic [NS*DW-1:0] stage_result;

    logic          stall, issue, stall_z, issue_z;
    logic [DW-1:0] ra_d, rb_d, ra_d_z, rb_d_z;
    logic [1:0]    ra_s, rb_s, ra_s_z, rb_s_z;
`ifdef HAZARD_PERF_EN
    logic [31:0] sc, fe, sc_z, fe_z;
    int unsigned m_sc, m_fe, m_sc_z, m_fe_z;
`endif

    int nchk = 0;
    int nerr = 0;
    eq_t q0, qz;

    always #5 clk = ~clk;

    always_comb
        for (int k = 0; k < NS; k++) stage_result[k*DW +: DW] = sr[k];

    pipe_hazard_ctrl #(.DATA_WIDTH(DW), .REG_ADDRESS_LENGTH(AW), .NUM_STAGES(NS),
                       .LOAD_LATENCY(LL), .ZERO_REG_HARDWIRED(0)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_ra_addr(id_ra_addr), .id_rb_addr(id_rb_addr),
        .id_ra_used(id_ra_used), .id_rb_used(id_rb_used),
        .id_rd_addr(id_rd_addr), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
        .id_ra_data(id_ra_data), .id_rb_data(id_rb_data),
        .stage_result(stage_result), .flush(flush),
        .stall(stall), .issue(issue),
        .fwd_ra_data(ra_d), .fwd_rb_data(rb_d),
        .fwd_ra_sel(ra_s), .fwd_rb_sel(rb_s)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(sc), .fwd_events(fe)
`endif
    );

    pipe_hazard_ctrl #(.DATA_WIDTH(DW), .REG_ADDRESS_LENGTH(AW), .NUM_STAGES(NS),
                       .LOAD_LATENCY(LL), .ZERO_REG_HARDWIRED(1)) dut_z (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_ra_addr(id_ra_addr), .id_rb_addr(id_rb_addr),
        .id_ra_used(id_ra_used), .id_rb_used(id_rb_used),
        .id_rd_addr(id_rd_addr), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
        .id_ra_data(id_ra_data), .id_rb_data(id_rb_data),
        .stage_result(stage_result), .flush(flush),
        .stall(stall_z), .issue(issue_z),
        .fwd_ra_data(ra_d_z), .fwd_rb_data(rb_d_z),
        .fwd_ra_sel(ra_s_z), .fwd_rb_sel(rb_s_z)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(sc_z), .fwd_events(fe_z)
`endif
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Position in the queue = how many stages past ID; first hit is youngest.
    function automatic int youngest(input eq_t q, input bit zr, input logic [AW-1:0] src,
                                    input logic used);
        if (!used || (zr && src == '0)) return -1;
        for (int i = 0; i < q.size(); i++)
            if (q[i].v && q[i].wr && q[i].rd == src) return i;
        return -1;
    endfunction

    // Expected outputs for one instance given its in-flight history.
    task automatic ref_check(input string nm, input eq_t q, input bit zr,
                             input logic o_stall, input logic o_issue,
                             input logic [1:0] o_sa, input logic [1:0] o_sb,
                             input logic [DW-1:0] o_da, input logic [DW-1:0] o_db,
                             output bit e_issue, output bit e_stall, output bit e_fwd);
        int  ia, ib;
        bit  haz;
        ia = youngest(q, zr, id_ra_addr, id_ra_used);
        ib = youngest(q, zr, id_rb_addr, id_rb_used);
        haz = (ia >= 0 && q[ia].ld && ia < LL) || (ib >= 0 && q[ib].ld && ib < LL);
        e_stall = id_valid && haz && !flush;
        e_issue = id_valid && !e_stall && !flush;
        e_fwd   = (ia >= 0) || (ib >= 0);
        chk({nm, "_stall"}, 64'(o_stall), 64'(e_stall));
        chk({nm, "_issue"}, 64'(o_issue), 64'(e_issue));
        chk({nm, "_ra_sel"}, 64'(o_sa), 64'(ia + 1));
        chk({nm, "_rb_sel"}, 64'(o_sb), 64'(ib + 1));
        chk({nm, "_ra_data"}, o_da, (ia < 0) ? id_ra_data : sr[ia]);
        chk({nm, "_rb_data"}, o_db, (ib < 0) ? id_rb_data : sr[ib]);
    endtask

    // Check the current cycle against the model, then advance one clock.
    task automatic cyc();
        bit is0, st0, fw0, isz, stz, fwz;
        #1;
        ref_check("n", q0, 1'b0, stall, issue, ra_s, rb_s, ra_d, rb_d, is0, st0, fw0);
        ref_check("z", qz, 1'b1, stall_z, issue_z, ra_s_z, rb_s_z, ra_d_z, rb_d_z, isz, stz, fwz);
`ifdef HAZARD_PERF_EN
        chk("n_stall_cycles", 64'(sc), 64'(m_sc));
        chk("n_fwd_events", 64'(fe), 64'(m_fe));
        chk("z_stall_cycles", 64'(sc_z), 64'(m_sc_z));
        chk("z_fwd_events", 64'(fe_z), 64'(m_fe_z));
        if (rst) begin
            m_sc = 0; m_fe = 0; m_sc_z = 0; m_fe_z = 0;
        end else begin
            m_sc   += st0;
            m_sc_z += stz;
            m_fe   += (is0 && fw0);
            m_fe_z += (isz && fwz);
        end
`endif
        if (rst) begin
            q0.delete();
            qz.delete();
        end else begin
            q0.push_front('{v: is0, wr: id_wr_en, ld: id_is_load, rd: id_rd_addr});
            qz.push_front('{v: isz, wr: id_wr_en, ld: id_is_load, rd: id_rd_addr});
            if (q0.size() > NS) void'(q0.pop_back());
            if (qz.size() > NS) void'(qz.pop_back());
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_id(input bit v, input int ra, input bit rau, input int rb, input bit rbu,
                          input int rd, input bit wr, input bit ld);
        id_valid   = v;
        id_ra_addr = AW'(ra);
        id_ra_used = rau;
        id_rb_addr = AW'(rb);
        id_rb_used = rbu;
        id_rd_addr = AW'(rd);
        id_wr_en   = wr;
        id_is_load = ld;
        id_ra_data = {$urandom, $urandom};
        id_rb_data = {$urandom, $urandom};
        for (int k = 0; k < NS; k++) sr[k] = {$urandom, $urandom};
        flush = 1'b0;
    endtask

    initial begin
`ifdef HAZARD_PERF_EN
        m_sc = 0; m_fe = 0; m_sc_z = 0; m_fe_z = 0;
`endif
        // Reset held two checked cycles after the first clearing edge.
        rst = 1'b1;
        set_id(1, 3, 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        repeat (2) begin
            #1;
            chk("rst_stall", 64'(stall), 64'd0);
            chk("rst_ra_sel", 64'(ra_s), 64'd0);
            chk("rst_ra_data", ra_d, id_ra_data);
            cyc();
        end
        rst = 1'b0;
        set_id(1, 3, 1, 3, 1, 3, 0, 0);
        #1 chk("post_rst_ra_sel", 64'(ra_s), 64'd0);
        cyc();

        // ALU back-to-back forward from entry 0.
        set_id(1, 0, 0, 0, 0, 5, 1, 0);
        cyc();
        set_id(1, 5, 1, 0, 0, 0, 0, 0);
        sr[0] = 64'hAA;
        #1;
        chk("alu_ra_sel", 64'(ra_s), 64'd1);
        chk("alu_ra_data", ra_d, 64'hAA);
        chk("alu_stall", 64'(stall), 64'd0);
        cyc();

        // Load-use: exactly one stall cycle, then forward from entry 1.
        set_id(1, 0, 0, 0, 0, 7, 1, 1);
        cyc();
        set_id(1, 0, 0, 7, 1, 0, 0, 0);
        #1;
        chk("lu_stall", 64'(stall), 64'd1);
        chk("lu_issue", 64'(issue), 64'd0);
        cyc();
        #1;
        chk("lu_stall_end", 64'(stall), 64'd0);
        chk("lu_rb_sel", 64'(rb_s), 64'd2);
        chk("lu_rb_data", rb_d, sr[1]);
        cyc();

        // Priority: the younger of two writers to r4 wins.
        set_id(1, 0, 0, 0, 0, 4, 1, 0);
        cyc();
        cyc();
        set_id(1, 4, 1, 0, 0, 0, 0, 0);
        sr[0] = 64'h1;
        sr[1] = 64'h2;
        #1;
        chk("prio_ra_sel", 64'(ra_s), 64'd1);
        chk("prio_ra_data", ra_d, 64'h1);
        cyc();

        // Flush beats a load-use hazard and leaves a bubble in entry 0.
        set_id(1, 0, 0, 0, 0, 9, 1, 1);
        cyc();
        set_id(1, 9, 1, 0, 0, 0, 0, 0);
        flush = 1'b1;
        #1;
        chk("flush_stall", 64'(stall), 64'd0);
        chk("flush_issue", 64'(issue), 64'd0);
        cyc();
        set_id(1, 9, 1, 0, 0, 0, 0, 0);
        #1;
        chk("flush_bubble_sel", 64'(ra_s), 64'd2);
        chk("flush_bubble_stall", 64'(stall), 64'd0);
        cyc();

        // Retirement: with no writers in flight, r5 comes from the regfile.
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (NS) cyc();
        set_id(1, 5, 1, 0, 0, 0, 0, 0);
        #1 chk("retire_ra_sel", 64'(ra_s), 64'd0);
        cyc();

        // r0: ordinary on one instance, never matched on the hardwired one.
        set_id(1, 0, 0, 0, 0, 0, 1, 1);
        cyc();
        set_id(1, 0, 1, 0, 1, 0, 0, 0);
        #1;
        chk("zero_z_ra_sel", 64'(ra_s_z), 64'd0);
        chk("zero_z_stall", 64'(stall_z), 64'd0);
        chk("zero_n_stall", 64'(stall), 64'd1);
        cyc();

        // Reset raised while stalled.
        set_id(1, 0, 0, 0, 0, 2, 1, 1);
        cyc();
        set_id(1, 2, 1, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1 chk("rst_mid_stall", 64'(stall), 64'd1);
        cyc();
        rst = 1'b0;
        #1 chk("rst_mid_stall_drop", 64'(stall), 64'd0);
        cyc();

        // Random traffic over a small register set to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            set_id($urandom_range(0, 3) != 0,
                   $urandom_range(0, 3), $urandom_range(0, 1) != 0,
                   $urandom_range(0, 3), $urandom_range(0, 1) != 0,
                   $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 49) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
